// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter multiplexing NCH emulated block devices onto the shared
// sd_rd/sd_wr/sd_ack sector interface, with mount gating and request timeout.
module sd_block_arbiter #(
  parameter int NCH     = 4,
  parameter int SECW    = 16,
  parameter int LBAW    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NCH-1:0]     ch_read,
  input  logic [NCH-1:0]     ch_write,
  input  logic [NCH*SECW-1:0] ch_sector,
  input  logic [NCH-1:0]     img_mounted,
  input  logic               img_size_nz,
  input  logic               img_readonly,
  input  logic [NCH-1:0]     sd_ack,
  output logic [NCH-1:0]     sd_rd,
  output logic [NCH-1:0]     sd_wr,
  output logic [LBAW-1:0]    sd_lba,
  output logic [NCH-1:0]     ch_wait,
  output logic [NCH-1:0]     ch_done,
  output logic [NCH-1:0]     ch_error,
  output logic [NCH-1:0]     ch_mounted,
  output logic [NCH-1:0]     ch_protect
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic              gnt_wr_q, gnt_wr_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [NCH-1:0]    rd_pend_q, rd_pend_d;
  logic [NCH-1:0]    wr_pend_q, wr_pend_d;
  logic [NCH-1:0]    wait_q, wait_d;
  logic [NCH-1:0]    done_q, done_d;
  logic [NCH-1:0]    err_q, err_d;
  logic [NCH-1:0]    mounted_q, mounted_d;
  logic [NCH-1:0]    protect_q, protect_d;
  logic [NCH-1:0]    ack_q;
  logic [NCH-1:0]    sd_rd_q, sd_rd_d;
  logic [NCH-1:0]    sd_wr_q, sd_wr_d;
  logic [LBAW-1:0]   lba_q, lba_d;
  logic [SECW-1:0]   sec_q [NCH];
  logic [SECW-1:0]   sec_d [NCH];

  logic [NCH-1:0]    rd_ok, wr_ok, gate_err, rd_clr, wr_clr, abort_d;
  logic              ack_rise, ack_fall, found;
  logic [IW-1:0]     g_sel;

  // Rotating search: first pending channel at or after the rr pointer.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_l;
    found = 1'b0;
    g_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      idx_l = IW'(idx);
      if (!found && (rd_pend_q[idx_l] || wr_pend_q[idx_l])) begin
        found = 1'b1;
        g_sel = idx_l;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_wr_d  = gnt_wr_q;
    rr_d      = rr_q;
    tcnt_d    = tcnt_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    lba_d     = lba_q;
    done_d    = '0;
    abort_d   = '0;
    rd_clr    = '0;
    wr_clr    = '0;
    mounted_d = mounted_q;
    protect_d = protect_q;
    sec_d     = sec_q;

    ack_rise = sd_ack[gnt_q] & ~ack_q[gnt_q];
    ack_fall = ~sd_ack[gnt_q] & ack_q[gnt_q];

    for (int i = 0; i < NCH; i++) begin
      if (img_mounted[i]) begin
        mounted_d[i] = img_size_nz;
        protect_d[i] = img_readonly;
      end
    end

    // Strobes on unmounted (or protected, for writes) channels are refused outright.
    rd_ok    = ch_read & mounted_q;
    wr_ok    = ch_write & mounted_q & ~protect_q;
    gate_err = (ch_read & ~rd_ok) | (ch_write & ~wr_ok);
    for (int i = 0; i < NCH; i++) begin
      if (rd_ok[i] || wr_ok[i]) sec_d[i] = ch_sector[i*SECW +: SECW];
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = REQ;
          gnt_d    = g_sel;
          gnt_wr_d = ~rd_pend_q[g_sel];
          tcnt_d   = '0;
          lba_d    = LBAW'(sec_q[g_sel]);
          if (rd_pend_q[g_sel]) sd_rd_d[g_sel] = 1'b1;
          else                  sd_wr_d[g_sel] = 1'b1;
        end
      end
      REQ: begin
        if (ack_rise) begin
          if (gnt_wr_q) wr_clr[gnt_q] = 1'b1;
          else          rd_clr[gnt_q] = 1'b1;
          sd_rd_d = '0;
          sd_wr_d = '0;
          state_d = XFER;
        end else if ((TIMEOUT > 0) && (tcnt_q == TLIM)) begin
          if (gnt_wr_q) wr_clr[gnt_q] = 1'b1;
          else          rd_clr[gnt_q] = 1'b1;
          sd_rd_d         = '0;
          sd_wr_d         = '0;
          abort_d[gnt_q]  = 1'b1;
          state_d         = IDLE;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      XFER: begin
        if (ack_fall) state_d = DONE;
      end
      DONE: begin
        done_d[gnt_q] = 1'b1;
        rr_d          = (gnt_q == LAST) ? '0 : gnt_q + 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new strobe beats a same-cycle clear of its pending bit.
    rd_pend_d = (rd_pend_q & ~rd_clr) | rd_ok;
    wr_pend_d = (wr_pend_q & ~wr_clr) | wr_ok;
    wait_d    = rd_pend_d | wr_pend_d | (wait_q & ~(done_d | abort_d));
    err_d     = gate_err | abort_d;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_wr_q  <= 1'b0;
      rr_q      <= '0;
      tcnt_q    <= '0;
      rd_pend_q <= '0;
      wr_pend_q <= '0;
      wait_q    <= '0;
      done_q    <= '0;
      err_q     <= '0;
      mounted_q <= '0;
      protect_q <= '0;
      ack_q     <= '0;
      sd_rd_q   <= '0;
      sd_wr_q   <= '0;
      lba_q     <= '0;
      for (int i = 0; i < NCH; i++) sec_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_wr_q  <= gnt_wr_d;
      rr_q      <= rr_d;
      tcnt_q    <= tcnt_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mounted_q <= mounted_d;
      protect_q <= protect_d;
      ack_q     <= sd_ack;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      lba_q     <= lba_d;
      sec_q     <= sec_d;
    end
  end

  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign sd_lba     = lba_q;
  assign ch_wait    = wait_q;
  assign ch_done    = done_q;
  assign ch_error   = err_q;
  assign ch_mounted = mounted_q;
  assign ch_protect = protect_q;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed bench for sd_block_arbiter: single read, round-robin, read+write,
// gating, timeout and asynchronous reset scenarios.
module tb_sd_block_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [3:0]  ch_read, ch_write, img_mounted, sd_ack;
  logic [63:0] ch_sector;
  logic        img_size_nz, img_readonly;
  logic [3:0]  sd_rd, sd_wr, ch_wait, ch_done, ch_error, ch_mounted, ch_protect;
  logic [31:0] sd_lba;

  int errors = 0;
  int checks = 0;

  sd_block_arbiter #(.NCH(4), .SECW(16), .LBAW(32), .TIMEOUT(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ch_read(ch_read), .ch_write(ch_write), .ch_sector(ch_sector),
    .img_mounted(img_mounted), .img_size_nz(img_size_nz), .img_readonly(img_readonly),
    .sd_ack(sd_ack), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba),
    .ch_wait(ch_wait), .ch_done(ch_done), .ch_error(ch_error),
    .ch_mounted(ch_mounted), .ch_protect(ch_protect)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    ch_read      = '0;
    ch_write     = '0;
    ch_sector    = '0;
    img_mounted  = '0;
    img_size_nz  = 1'b0;
    img_readonly = 1'b0;
    sd_ack       = '0;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
  endtask

  task automatic mount(input int ch, input logic sz, input logic ro);
    img_mounted[ch] = 1'b1;
    img_size_nz     = sz;
    img_readonly    = ro;
    tick();
    img_mounted = '0;
  endtask

  // Waits for a request, answers the ack handshake, then waits for ch_done.
  task automatic serve(input bit inject0, output int ch, output logic [3:0] rdv,
                       output logic [3:0] wrv, output bit ok);
    int n;
    ch = -1; ok = 1'b0; rdv = '0; wrv = '0; n = 0;
    while ((sd_rd | sd_wr) == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    if ((sd_rd | sd_wr) == 4'b0) return;
    rdv = sd_rd;
    wrv = sd_wr;
    for (int i = 0; i < 4; i++) if (rdv[i] | wrv[i]) ch = i;
    sd_ack[ch] = 1'b1;
    tick();
    if (inject0) ch_read[0] = 1'b1;
    tick();
    ch_read[0] = 1'b0;
    sd_ack[ch] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ch_done[ch]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++;
    if ({sd_rd, sd_wr, ch_wait, ch_done, ch_error, ch_mounted, ch_protect} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {sd_rd, sd_wr, ch_wait, ch_done, ch_error, ch_mounted, ch_protect});
    end
    checks++;
    if (sd_lba !== 32'h0) begin
      errors++;
      $display("FAIL reset_lba: got %h expected 0", sd_lba);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    mount(1, 1'b1, 1'b0);
    ch_sector[31:16] = 16'h0123;
    ch_read[1] = 1'b1;                    // cycle T
    tick();                               // T+1
    ch_read = '0;
    checks++;
    if (ch_wait[1] !== 1'b1) begin errors++; $display("FAIL t1_wait_T1: got %b expected 1", ch_wait[1]); end
    tick();                               // T+2
    checks++;
    if (sd_rd !== 4'b0010) begin errors++; $display("FAIL t1_sd_rd_T2: got %b expected 0010", sd_rd); end
    checks++;
    if (sd_lba !== 32'h0000_0123) begin errors++; $display("FAIL t1_lba_T2: got %h expected 00000123", sd_lba); end
    repeat (3) tick();                    // T+5
    sd_ack[1] = 1'b1;
    tick();                               // T+6
    checks++;
    if (sd_rd !== 4'b0000) begin errors++; $display("FAIL t1_sd_rd_T6: got %b expected 0000", sd_rd); end
    repeat (3) tick();                    // T+9
    sd_ack[1] = 1'b0;
    tick();                               // T+10
    checks++;
    if (ch_done !== 4'b0000) begin errors++; $display("FAIL t1_done_T10: got %b expected 0000", ch_done); end
    checks++;
    if (sd_lba !== 32'h0000_0123) begin errors++; $display("FAIL t1_lba_hold: got %h expected 00000123", sd_lba); end
    tick();                               // T+11
    checks++;
    if (ch_done !== 4'b0010) begin errors++; $display("FAIL t1_done_T11: got %b expected 0010", ch_done); end
    checks++;
    if (ch_wait[1] !== 1'b0) begin errors++; $display("FAIL t1_wait_T11: got %b expected 0", ch_wait[1]); end
    tick();                               // T+12
    checks++;
    if (ch_done !== 4'b0000) begin errors++; $display("FAIL t1_done_T12: got %b expected 0000", ch_done); end
  endtask

  task automatic test_round_robin();
    int         ch;
    logic [3:0] rdv, wrv;
    bit         ok;
    int         exp_order [4] = '{0, 2, 3, 0};
    do_reset();
    mount(0, 1'b1, 1'b0);
    mount(2, 1'b1, 1'b0);
    mount(3, 1'b1, 1'b0);
    ch_read = 4'b1101;
    tick();
    ch_read = '0;
    for (int s = 0; s < 4; s++) begin
      serve(s == 1, ch, rdv, wrv, ok);
      checks++;
      if (ch !== exp_order[s]) begin
        errors++;
        $display("FAIL rr_grant_%0d: got ch %0d expected ch %0d", s, ch, exp_order[s]);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_done_%0d: got no done expected done", s); end
    end
  endtask

  task automatic test_read_write_same_ch();
    int         ch;
    logic [3:0] rdv, wrv;
    bit         ok;
    do_reset();
    mount(2, 1'b1, 1'b0);
    ch_read[2]  = 1'b1;
    ch_write[2] = 1'b1;
    tick();
    ch_read  = '0;
    ch_write = '0;
    serve(1'b0, ch, rdv, wrv, ok);
    checks++;
    if ({rdv, wrv} !== 8'b0100_0000) begin errors++; $display("FAIL rw_first_is_read: got rd %b wr %b expected rd 0100 wr 0000", rdv, wrv); end
    checks++;
    if (!ok || ch_wait[2] !== 1'b1) begin errors++; $display("FAIL rw_wait_held: got done %b wait %b expected 1 1", ok, ch_wait[2]); end
    serve(1'b0, ch, rdv, wrv, ok);
    checks++;
    if ({rdv, wrv} !== 8'b0000_0100) begin errors++; $display("FAIL rw_second_is_write: got rd %b wr %b expected rd 0000 wr 0100", rdv, wrv); end
    checks++;
    if (!ok || ch_wait[2] !== 1'b0) begin errors++; $display("FAIL rw_wait_release: got done %b wait %b expected 1 0", ok, ch_wait[2]); end
  endtask

  task automatic test_gating();
    do_reset();
    mount(3, 1'b1, 1'b1);
    ch_write[3] = 1'b1;
    tick();
    ch_write = '0;
    checks++;
    if (ch_error !== 4'b1000) begin errors++; $display("FAIL gate_prot_error: got %b expected 1000", ch_error); end
    checks++;
    if (ch_wait[3] !== 1'b0) begin errors++; $display("FAIL gate_prot_wait: got %b expected 0", ch_wait[3]); end
    tick();
    tick();
    checks++;
    if ({sd_wr, ch_error} !== 8'h00) begin errors++; $display("FAIL gate_prot_no_req: got wr %b err %b expected 0000 0000", sd_wr, ch_error); end
    ch_read[0] = 1'b1;
    tick();
    ch_read = '0;
    checks++;
    if (ch_error !== 4'b0001) begin errors++; $display("FAIL gate_unmnt_error: got %b expected 0001", ch_error); end
    checks++;
    if (ch_wait !== 4'b0000) begin errors++; $display("FAIL gate_unmnt_wait: got %b expected 0000", ch_wait); end
    tick();
    tick();
    checks++;
    if (sd_rd !== 4'b0000) begin errors++; $display("FAIL gate_unmnt_no_req: got %b expected 0000", sd_rd); end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    mount(0, 1'b1, 1'b0);
    mount(1, 1'b1, 1'b0);
    ch_read = 4'b0011;
    tick();                               // T+1
    ch_read = '0;
    tick();                               // T+2
    cnt = 0;
    while (sd_rd == 4'b0001 && cnt < 20) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== 8) begin errors++; $display("FAIL to_req_cycles: got %0d expected 8", cnt); end
    checks++;
    if (ch_error !== 4'b0001) begin errors++; $display("FAIL to_error: got %b expected 0001", ch_error); end
    checks++;
    if (ch_wait !== 4'b0010) begin errors++; $display("FAIL to_wait: got %b expected 0010", ch_wait); end
    tick();
    checks++;
    if (sd_rd !== 4'b0010) begin errors++; $display("FAIL to_next_grant: got %b expected 0010", sd_rd); end
    checks++;
    if (ch_error !== 4'b0000) begin errors++; $display("FAIL to_error_pulse: got %b expected 0000", ch_error); end
  endtask

  task automatic test_async_reset();
    int         ch;
    logic [3:0] rdv, wrv;
    bit         ok;
    do_reset();
    mount(1, 1'b1, 1'b1);
    ch_sector[31:16] = 16'h0055;
    ch_read[1] = 1'b1;
    tick();
    ch_read = '0;
    tick();                               // REQ
    sd_ack[1] = 1'b1;
    tick();                               // XFER
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({sd_rd, sd_wr, ch_wait, ch_done, ch_error, ch_mounted, ch_protect} !== 28'h0) begin
      errors++;
      $display("FAIL areset_outputs: got %h expected 0",
               {sd_rd, sd_wr, ch_wait, ch_done, ch_error, ch_mounted, ch_protect});
    end
    checks++;
    if (sd_lba !== 32'h0) begin errors++; $display("FAIL areset_lba: got %h expected 0", sd_lba); end
    sd_ack = '0;
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    mount(1, 1'b1, 1'b0);
    ch_sector[31:16] = 16'h0077;
    ch_read[1] = 1'b1;
    tick();
    ch_read = '0;
    tick();
    checks++;
    if (sd_lba !== 32'h0000_0077) begin errors++; $display("FAIL areset_fresh_lba: got %h expected 00000077", sd_lba); end
    serve(1'b0, ch, rdv, wrv, ok);
    checks++;
    if (ch !== 1 || !ok) begin errors++; $display("FAIL areset_fresh_serve: got ch %0d done %b expected ch 1 done 1", ch, ok); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_read_write_same_ch();
    test_gating();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Multiplexes up to NCH emulated block devices onto the shared MiSTer sd_rd/sd_wr/sd_ack sector interface. Devices include HDD slots and 3.5"/5.25" drive images.
- Latches per-channel read and write strobes, arbitrates round-robin, and drives each channel's sector LBA.
- Sequences the ack rise/fall handshake and holds a per-channel CPU wait until that channel's transfer finishes.
- Adds mount gating and a request timeout with an error report.
- Sits between top (device controllers) and the HPS sd interface in emu.

Parameters:
- NCH, 4, number of channels; range 1..10, matching the sd_* vector width.
- SECW, 16, width of each channel's sector number.
- LBAW, 32, width of sd_lba; must be >= SECW.
- TIMEOUT, 0, cycles allowed in REQ before abort; 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ch_read  in  NCH  per-channel read strobe, 1-cycle pulse.
- ch_write  in  NCH  per-channel write strobe, 1-cycle pulse.
- ch_sector  in  NCH*SECW  packed sector numbers; channel i occupies [i*SECW +: SECW].
- img_mounted  in  NCH  mount-change pulse per channel.
- img_size_nz  in  1  image size is non-zero; qualifies img_mounted.
- img_readonly  in  1  image read-only flag; qualifies img_mounted.
- sd_ack  in  NCH  HPS acknowledge per channel.
- sd_rd  out  NCH  read request.
- sd_wr  out  NCH  write request.
- sd_lba  out  LBAW  LBA of the granted channel.
- ch_wait  out  NCH  per-channel CPU wait.
- ch_done  out  NCH  1-cycle pulse on successful completion.
- ch_error  out  NCH  1-cycle pulse on abort (unmounted, protected, or timeout).
- ch_mounted  out  NCH  mounted status.
- ch_protect  out  NCH  write-protect status.

Behaviour:
- **Reset:** reset_n low clears all outputs, pending bits, sector registers, the round-robin pointer and the timeout counter. This includes ch_mounted and ch_protect. FSM goes to IDLE. Reset mid-transfer drops sd_rd/sd_wr immediately; no done/error pulse is issued.
- **Mount:** on img_mounted[i], ch_mounted[i] <= img_size_nz and ch_protect[i] <= img_readonly.
- **Capture:** a strobe at cycle T sets rd_pend[i] or wr_pend[i] and the sector register at edge T+1. ch_wait[i] is high from T+1.
- **Wait release:** ch_wait[i] falls in the same cycle ch_done[i] or ch_error[i] pulses, unless the other pending bit for that channel is still set.
- **Strobe vs clear:** a strobe arriving in the same cycle as its pending bit is cleared wins; the bit stays set.
- **Gating:** a read strobe on an unmounted channel, or a write strobe on an unmounted or protected channel, does not set pending. Instead it pulses ch_error[i] at T+1, and ch_wait stays low.
- **FSM states:** IDLE, REQ, XFER, DONE.
- **IDLE:** if any pending bit is set, grant the lowest index at or after the rr pointer (wrapping) that has a pending bit.
  - Read has priority over write within a channel.
  - At the next edge go to REQ, assert sd_rd[g] or sd_wr[g] (never both), and load sd_lba with the zero-extended sector register.
  - Best case: strobe at T, pending at T+1, sd_rd at T+2.
- **REQ:**
  - On an sd_ack[g] rising edge (1-cycle registered ack history), clear the granted pending bit, drop sd_rd/sd_wr, and go to XFER.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 without a rising edge: drop the request, clear that pending bit, pulse ch_error[g], and go to IDLE.
- **XFER:** on an sd_ack[g] falling edge, go to DONE. sd_lba is held constant throughout.
- **DONE:** pulse ch_done[g] for one cycle, set rr pointer to g+1 mod NCH, and go to IDLE.
- **Isolation:** sd_ack bits of non-granted channels are ignored. A strobe on the granted channel during REQ/XFER updates its sector register but does not disturb sd_lba.
- **Timeout counter:** cleared on entry to REQ, saturating, width clog2(TIMEOUT+1).

Test Plan:
1. **Single read:** mount ch1 (size_nz=1), ch_sector[1]=16'h0123, ch_read[1] pulse at T.
   - Required: ch_wait[1] high at T+1; sd_rd=4'b0010 and sd_lba=32'h0000_0123 at T+2.
   - Ack rise at T+5 drops sd_rd at T+6; ack fall at T+9 gives ch_done[1] at T+11 and ch_wait[1] low.
2. **Round-robin:** ch0, ch2 and ch3 reads strobed together, ack handshake answered each time.
   - Required grant order is 0, 2, 3.
   - A second ch0 read issued during ch2's XFER is served after ch3.
3. **Read+write on one channel:** ch2 read and write strobed in the same cycle.
   - Required: the read transaction completes first, then sd_wr=4'b0100. ch_wait[2] stays high until the write's ch_done.
4. **Gating:**
   - Write to protected ch3: ch_error[3] pulse at T+1, no sd_wr, ch_wait[3] low.
   - Read to unmounted ch0: same behaviour.
5. **Timeout:** TIMEOUT=8, ack never returned.
   - Required: sd_rd drops after 8 REQ cycles, then a ch_error pulse, FSM back in IDLE, and the next pending channel is granted.
6. **Async reset:** reset_n pulled low during XFER.
   - Required: all outputs 0 without a clock edge; after release, a fresh request is served normally.
